// File: rtl/ss_arb_pkg.sv
// ---------------------------------------------------------------------------
// ss_arb_pkg
// Shared definitions for the seven-segment display arbiter.
//   arb_state_e  : arbiter FSM states; the encoding matches the grant vector
//                  presented by the owner (IDLE = 00, OWN0 = 01, OWN1 = 10).
//   NUM_REQ      : number of display requesters.
//   state_grant  : maps a state onto its one-hot-or-zero grant vector.
// ---------------------------------------------------------------------------
package ss_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] state_grant(input arb_state_e s);
        logic [NUM_REQ-1:0] g;
        g    = '0;
        g[0] = (s == ST_OWN0);
        g[1] = (s == ST_OWN1);
        return g;
    endfunction

endpackage

// File: rtl/ss_blank_gen.sv
// ---------------------------------------------------------------------------
// ss_blank_gen
// Combinational leading-zero blanking for a four-digit display word.
// A digit is dark when it and every more-significant digit are zero.
// Digit 0 always stays lit so a value of zero still shows a single "0".
//   digits_i [15:0] : four 4-bit digits, digit 0 in [3:0]
//   blank_o  [3:0]  : per-digit blank, 1 = digit dark
// ---------------------------------------------------------------------------
module ss_blank_gen (
    input  logic [15:0] digits_i,
    output logic [3:0]  blank_o
);

    logic zero3;
    logic zero2;
    logic zero1;

    assign zero3 = (digits_i[15:12] == 4'h0);
    assign zero2 = (digits_i[11:8]  == 4'h0);
    assign zero1 = (digits_i[7:4]   == 4'h0);

    assign blank_o = {zero3,
                      zero3 & zero2,
                      zero3 & zero2 & zero1,
                      1'b0};

endmodule

// File: rtl/ss_display_arbiter.sv
// ---------------------------------------------------------------------------
// ss_display_arbiter
// Shares one seven-segment display between two requesters. An owner keeps
// the display for at least HOLD_CYCLES clocks; when its tenure expires the
// display rotates to the other requester if that one is asking, otherwise
// the owner simply starts a fresh tenure. Ties from IDLE go to whichever
// requester was not served last. All outputs are registered and change in
// the same cycle as grant.
//
// Parameters
//   HOLD_CYCLES   : minimum tenure in clk cycles before rotation
//   BLANK_LEADING : 1 = dark leading-zero digits of the granted data
// Ports
//   clk        : system clock, rising edge
//   btnc       : synchronous active-high reset
//   req[1:0]   : per-requester display request
//   data0/1    : four digits per requester, digit 0 in [3:0]
//   dp0/1      : per-requester decimal-point pattern
//   grant      : one-hot-or-zero current owner
//   disp_data  : digits to the seven-segment controller
//   disp_blank : per-digit blank, 1 = dark
//   disp_dp    : decimal points to the seven-segment controller
// ---------------------------------------------------------------------------
module ss_display_arbiter
    import ss_arb_pkg::*;
#(
    parameter int HOLD_CYCLES   = 100_000_000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               btnc,
    input  logic [NUM_REQ-1:0] req,
    input  logic [15:0]        data0,
    input  logic [15:0]        data1,
    input  logic [3:0]         dp0,
    input  logic [3:0]         dp1,
    output logic [NUM_REQ-1:0] grant,
    output logic [15:0]        disp_data,
    output logic [3:0]         disp_blank,
    output logic [3:0]         disp_dp
);

    // A one-cycle tenure still needs a 1-bit counter to stay well formed.
    localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               last_q,  last_d;   // index of the requester served last

    logic [NUM_REQ-1:0] grant_q;
    logic [15:0]        data_q;
    logic [3:0]         blank_q;
    logic [3:0]         dp_q;

    logic [15:0]        sel_data;
    logic [3:0]         sel_dp;
    logic [3:0]         sel_blank;
    logic [3:0]         lz_blank;

    // Next-state decision
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req[0] && req[1]) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (req[0]) begin
                    state_d = ST_OWN0;
                end else if (req[1]) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req[0]) begin
                    // Release: hand straight over with no idle gap if possible.
                    last_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = req[1] ? ST_OWN1 : ST_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    // Tenure expired: rotate only if the other side is waiting.
                    cnt_d = '0;
                    if (req[1]) begin
                        last_d  = 1'b0;
                        state_d = ST_OWN1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OWN1: begin
                if (!req[1]) begin
                    last_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = req[0] ? ST_OWN0 : ST_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (req[0]) begin
                        last_d  = 1'b1;
                        state_d = ST_OWN0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output source follows the next owner so data and grant move together.
    always_comb begin
        sel_data  = 16'h0000;
        sel_dp    = 4'b0000;
        sel_blank = 4'b1111;
        unique case (state_d)
            ST_OWN0: begin
                sel_data  = data0;
                sel_dp    = dp0;
                sel_blank = BLANK_LEADING ? lz_blank : 4'b0000;
            end
            ST_OWN1: begin
                sel_data  = data1;
                sel_dp    = dp1;
                sel_blank = BLANK_LEADING ? lz_blank : 4'b0000;
            end
            default: ;
        endcase
    end

    ss_blank_gen u_blank_gen (
        .digits_i (sel_data),
        .blank_o  (lz_blank)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (btnc) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            grant_q <= '0;
            data_q  <= 16'h0000;
            blank_q <= 4'b1111;
            dp_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= state_grant(state_d);
            data_q  <= sel_data;
            blank_q <= sel_blank;
            dp_q    <= sel_dp;
        end
    end

    assign grant      = grant_q;
    assign disp_data  = data_q;
    assign disp_blank = blank_q;
    assign disp_dp    = dp_q;

endmodule
